debug_ring_router_multi: RTL and testbench
==========================================

// Module: debug_ring_router_multi
// PURPOSE
//  Parametrised DII ring router for a single debug-ring stop. Serves RINGS
//  independent ring lanes plus one local port. Each lane has an input FIFO.
//  Every lane either ejects a packet to the local port or forwards it on the
//  same lane. Local packets are injected on lane 0. Arbitration is round-robin
//  and packet-atomic. Instantiated once per ring stop by the ring top level.
// PARAMETERS
//  RINGS        2   number of ring lanes (>=1)
//  BUFFER_SIZE  4   flit depth of each lane FIFO and of the local FIFO (>=2)
//  ID_WIDTH     10  width of the destination field in the head flit
// PORTS
//  clk            in   1            clock
//  rst            in   1            async reset, active-high
//  id             in   ID_WIDTH     this stop's address; static after reset
//  ring_in_data   in   RINGS*16     per-lane flit, lane r at [16r+:16]
//  ring_in_last   in   RINGS        per-lane last-flit flag
//  ring_in_valid  in   RINGS        per-lane valid
//  ring_in_ready  out  RINGS        per-lane ready
//  ring_out_data  out  RINGS*16     per-lane forwarded flit
//  ring_out_last  out  RINGS        per-lane last-flit flag
//  ring_out_valid out  RINGS        per-lane valid
//  ring_out_ready in   RINGS        per-lane ready
//  local_in_data/last/valid  in  16/1/1  injection from the local module
//  local_in_ready            out 1       local FIFO can accept a flit
//  local_out_data/last/valid out 16/1/1  ejection to the local module
//  local_out_ready           in  1       local module can accept a flit
// BEHAVIOUR
//  Transfer rule: a flit moves when valid&&ready on the same rising edge.
//  valid never depends combinationally on ready.
//  Reset (async): all FIFOs empty; all *_valid=0; all *_ready=0 while rst=1.
//  Arbiters go to IDLE; round-robin pointers go to 0.
//  FIFOs: registered storage; ready = (count < BUFFER_SIZE), independent of
//   the output side. When full, push and pop on the same edge is not
//   possible (ready=0). Pointers wrap modulo BUFFER_SIZE.
//   Min latency: a flit accepted at edge N is visible at the output after N+1.
//  Head classification (per lane, on head flit at the FIFO output):
//   dest = data[ID_WIDTH-1:0]; dest==id -> EJECT, else -> FWD.
//  Lane state machine: IDLE -> EJECT or FWD when a head flit is present.
//   Return to IDLE after the flit with last=1 transfers.
//   Flits of one packet are never interleaved with another packet.
//   Single-flit packet (last=1 on head) enters the state and leaves it on
//   the same transfer edge.
//  Ejection arbiter: lanes in EJECT request local_out.
//   Round-robin, starting from rr_ej+1. The grant holds until the granted
//   packet's last flit transfers; then rr_ej = granted lane.
//   Ungranted EJECT lanes stall; their FIFOs back-pressure ring_in.
//  Lane-0 output arbiter: lane-0 FWD traffic vs the local FIFO.
//   Two-way round-robin at packet boundaries. The grant holds until last.
//   Ties: the side not served last wins; after reset, ring traffic wins.
//   Local packets are always forwarded, even if dest==id.
//  Lanes r>0: ring_out[r] carries only lane-r FWD traffic.
//  Simultaneous events:
//   - Ejection and forwarding on different lanes proceed in the same cycle.
//   - A lane may push and pop in the same cycle.
//  rst asserted mid-packet: partial packets are discarded and state returns
//   to reset values immediately. No flit is emitted until rst deasserts.
//  No packet filtering or checking. A dest that matches no stop circulates;
//   preventing this is a system-level rule.
// TESTING
//  1 id=3; lane0 head 0x0003 + 1 flit last -> both flits on local_out, in
//    order; ring_out_valid[0] stays 0.
//  2 id=3; lane1 3-flit pkt, dest 0x0005 -> appears unchanged on
//    ring_out[1], first valid one cycle after accept.
//  3 Lanes 0 and 1 both inject a 2-flit pkt to dest 3 in the same cycle ->
//    lane1 packet fully, then lane0 (rr_ej=0 after reset). No interleave.
//  4 Local 2-flit pkt and lane0 FWD pkt pending together -> ring first, then
//    local on ring_out[0]. Repeat -> local served first.
//  5 Hold local_out_ready=0 and push 5 eject flits on lane0 ->
//    ring_in_ready[0] drops after 4 accepted. Release -> all 5 arrive in
//    order.
//  6 Assert rst mid-packet on lane1 -> outputs valid=0 that cycle. After
//    release, a new packet routes correctly with no stale flits.

Source files
------------

// File: rtl/debug_ring_router_multi.sv
// debug_ring_router_multi: one debug-ring stop routing RINGS lanes plus a local port.
// Each lane ejects to the local port or forwards on itself; local packets join lane 0.
module debug_ring_router_multi_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] in_flit,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [16:0] out_flit,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int PW = $clog2(DEPTH);
    logic [16:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          push, pop;
    assign in_ready  = !rst && int'(count) < DEPTH;
    assign out_valid = count != '0;
    assign out_flit  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= in_flit;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (int'(wr_ptr) == DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= (int'(rd_ptr) == DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
endmodule

module debug_ring_router_multi #(
    parameter int RINGS       = 2,
    parameter int BUFFER_SIZE = 4,
    parameter int ID_WIDTH    = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_WIDTH-1:0] id,
    input  logic [RINGS*16-1:0] ring_in_data,
    input  logic [RINGS-1:0]    ring_in_last,
    input  logic [RINGS-1:0]    ring_in_valid,
    output logic [RINGS-1:0]    ring_in_ready,
    output logic [RINGS*16-1:0] ring_out_data,
    output logic [RINGS-1:0]    ring_out_last,
    output logic [RINGS-1:0]    ring_out_valid,
    input  logic [RINGS-1:0]    ring_out_ready,
    input  logic [15:0]         local_in_data,
    input  logic                local_in_last,
    input  logic                local_in_valid,
    output logic                local_in_ready,
    output logic [15:0]         local_out_data,
    output logic                local_out_last,
    output logic                local_out_valid,
    input  logic                local_out_ready
);
    localparam int LW = RINGS > 1 ? $clog2(RINGS) : 1;
    typedef enum logic [1:0] {IDLE, EJECT, FWD} mode_t;
    logic [RINGS-1:0][16:0] head;
    logic [RINGS-1:0]       head_valid, pop, ej_req, fwd_req;
    logic [16:0]            loc_head;
    logic                   loc_valid, loc_pop;
    logic                   ej_busy, ej_xfer;
    logic [LW-1:0]          rr_ej, ej_grant, ej_pick, ej_cur;
    int                     ej_best;
    logic                   o_busy, o_sel_ring, o_last_ring, o_pick_ring, o_ring, o_xfer;

    for (genvar r = 0; r < RINGS; r++) begin : g_lane
        mode_t state, state_nx, mode;
        debug_ring_router_multi_fifo #(.DEPTH(BUFFER_SIZE)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .in_flit   ({ring_in_last[r], ring_in_data[16*r+:16]}),
            .in_valid  (ring_in_valid[r]),
            .in_ready  (ring_in_ready[r]),
            .out_flit  (head[r]),
            .out_valid (head_valid[r]),
            .out_ready (pop[r])
        );
        always_ff @(posedge clk or posedge rst)
            if (rst) state <= IDLE;
            else state <= state_nx;
        always_comb state_nx = (pop[r] && head[r][16]) ? IDLE : mode;
        // A head flit is classified combinationally so single-flit packets pass in one edge
        always_comb mode = state != IDLE ? state :
                           !head_valid[r] ? IDLE :
                           head[r][ID_WIDTH-1:0] == id ? EJECT : FWD;
        assign ej_req[r]  = mode == EJECT;
        assign fwd_req[r] = mode == FWD;
        assign pop[r] = (ej_xfer && int'(ej_cur) == r) ||
                        (r == 0 ? o_xfer && o_ring : fwd_req[r] && head_valid[r] && ring_out_ready[r]);
    end

    debug_ring_router_multi_fifo #(.DEPTH(BUFFER_SIZE)) u_local_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_flit   ({local_in_last, local_in_data}),
        .in_valid  (local_in_valid),
        .in_ready  (local_in_ready),
        .out_flit  (loc_head),
        .out_valid (loc_valid),
        .out_ready (loc_pop)
    );

    // Round-robin: smallest distance past the last served lane wins
    always_comb begin
        ej_pick = '0;
        ej_best = RINGS;
        for (int i = 0; i < RINGS; i++)
            if (ej_req[i] && (i + RINGS - 1 - int'(rr_ej)) % RINGS < ej_best) begin
                ej_best = (i + RINGS - 1 - int'(rr_ej)) % RINGS;
                ej_pick = LW'(i);
            end
    end
    assign ej_cur          = ej_busy ? ej_grant : ej_pick;
    assign local_out_valid = ej_req[ej_cur] && head_valid[ej_cur];
    assign local_out_data  = head[ej_cur][15:0];
    assign local_out_last  = head[ej_cur][16];
    assign ej_xfer         = local_out_valid && local_out_ready;

    assign o_pick_ring = fwd_req[0] && (!loc_valid || !o_last_ring);
    assign o_ring      = o_busy ? o_sel_ring : o_pick_ring;
    assign o_xfer      = ring_out_valid[0] && ring_out_ready[0];
    assign loc_pop     = o_xfer && !o_ring;

    always_comb begin
        for (int i = 0; i < RINGS; i++) begin
            ring_out_data[16*i+:16] = head[i][15:0];
            ring_out_last[i]        = head[i][16];
            ring_out_valid[i]       = fwd_req[i] && head_valid[i];
        end
        ring_out_data[15:0] = o_ring ? head[0][15:0] : loc_head[15:0];
        ring_out_last[0]    = o_ring ? head[0][16] : loc_head[16];
        ring_out_valid[0]   = o_ring ? fwd_req[0] && head_valid[0] : loc_valid;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ej_busy     <= 1'b0;
            ej_grant    <= '0;
            rr_ej       <= '0;
            o_busy      <= 1'b0;
            o_sel_ring  <= 1'b0;
            o_last_ring <= 1'b0;
        end else begin
            if (ej_xfer) begin
                ej_busy  <= !local_out_last;
                ej_grant <= ej_cur;
                if (local_out_last) rr_ej <= ej_cur;
            end
            if (o_xfer) begin
                o_busy     <= !ring_out_last[0];
                o_sel_ring <= o_ring;
                if (ring_out_last[0]) o_last_ring <= o_ring;
            end
        end
endmodule

// File: tb/tb_debug_ring_router_multi.sv
// tb_debug_ring_router_multi: randomized and directed checks of the two-lane router
// against a packet scoreboard built from the routing rules.
module tb_debug_ring_router_multi;
    typedef logic [16:0] flit_t;
    localparam logic [9:0] MY_ID = 10'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  id = MY_ID;
    logic [31:0] ring_in_data;
    logic [1:0]  ring_in_last, ring_in_valid, ring_in_ready;
    logic [31:0] ring_out_data;
    logic [1:0]  ring_out_last, ring_out_valid, ring_out_ready;
    logic [15:0] local_in_data, local_out_data;
    logic        local_in_last, local_in_valid, local_in_ready;
    logic        local_out_last, local_out_valid, local_out_ready;

    int    n_err = 0, n_chk = 0;
    flit_t drv [3][$];
    flit_t exp_q [5][$];
    int    cur_q [3];
    int    ord_ej[$], ord_o0[$];
    int    o0_valid_cnt;
    bit    gaps, rand_rdy;
    logic [1:0] ro_rdy;
    logic       lo_rdy;
    logic [3:0] seq [3];

    debug_ring_router_multi #(.RINGS(2), .BUFFER_SIZE(4), .ID_WIDTH(10)) dut (
        .clk             (clk),
        .rst             (rst),
        .id              (id),
        .ring_in_data    (ring_in_data),
        .ring_in_last    (ring_in_last),
        .ring_in_valid   (ring_in_valid),
        .ring_in_ready   (ring_in_ready),
        .ring_out_data   (ring_out_data),
        .ring_out_last   (ring_out_last),
        .ring_out_valid  (ring_out_valid),
        .ring_out_ready  (ring_out_ready),
        .local_in_data   (local_in_data),
        .local_in_last   (local_in_last),
        .local_in_valid  (local_in_valid),
        .local_in_ready  (local_in_ready),
        .local_out_data  (local_out_data),
        .local_out_last  (local_out_last),
        .local_out_valid (local_out_valid),
        .local_out_ready (local_out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] rand_dest();
        return 10'($urandom_range(0, 1) ? $urandom_range(0, 2) : $urandom_range(4, 1023));
    endfunction

    // Queues: 0/1 eject from lane 0/1, 2 forward lane 1, 3 lane-0 forward, 4 local inject
    task automatic make_pkt(input int src, input logic [9:0] d, input int len);
        int    q;
        flit_t f;
        q = src == 2 ? 4 : d == MY_ID ? src : src == 0 ? 3 : 2;
        for (int i = 0; i < len; i++) begin
            f[16]   = i == len - 1;
            f[15:0] = i == 0 ? {src[1:0], seq[src], d} : 16'($urandom);
            drv[src].push_back(f);
            exp_q[q].push_back(f);
        end
        seq[src] = seq[src] + 1'b1;
    endtask

    task automatic observe(input int p, input flit_t f);
        int    q;
        flit_t e;
        if (cur_q[p] < 0)
            cur_q[p] = p == 0 ? (f[15:14] == 2'd0 ? 0 : f[15:14] == 2'd1 ? 1 : -1) :
                       p == 1 ? (f[15:14] == 2'd0 ? 3 : f[15:14] == 2'd2 ? 4 : -1) : 2;
        q = cur_q[p];
        chk($sformatf("known_src_p%0d", p), 32'(q >= 0), 32'd1);
        if (q >= 0) begin
            chk($sformatf("pending_p%0d", p), 32'(exp_q[q].size() > 0), 32'd1);
            if (exp_q[q].size() > 0) begin
                e = exp_q[q].pop_front();
                chk($sformatf("flit_p%0d", p), 32'(f), 32'(e));
            end
        end
        if (f[16]) begin
            if (p == 0) ord_ej.push_back(q);
            if (p == 1) ord_o0.push_back(q);
            cur_q[p] = -1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            ring_in_valid[s] = drv[s].size() > 0 && (!gaps || $urandom_range(0, 3) != 0);
            {ring_in_last[s], ring_in_data[16*s+:16]} = drv[s].size() > 0 ? drv[s][0] : 17'd0;
        end
        local_in_valid = drv[2].size() > 0 && (!gaps || $urandom_range(0, 3) != 0);
        {local_in_last, local_in_data} = drv[2].size() > 0 ? drv[2][0] : 17'd0;
        ring_out_ready  = rand_rdy ? 2'($urandom_range(0, 3)) : ro_rdy;
        local_out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : lo_rdy;
        #1;
        for (int s = 0; s < 2; s++)
            if (ring_in_valid[s] && ring_in_ready[s]) void'(drv[s].pop_front());
        if (local_in_valid && local_in_ready) void'(drv[2].pop_front());
        if (ring_out_valid[0]) o0_valid_cnt++;
        if (local_out_valid && local_out_ready) observe(0, {local_out_last, local_out_data});
        if (ring_out_valid[0] && ring_out_ready[0]) observe(1, {ring_out_last[0], ring_out_data[15:0]});
        if (ring_out_valid[1] && ring_out_ready[1]) observe(2, {ring_out_last[1], ring_out_data[31:16]});
    endtask

    function automatic bit busy();
        int n = 0;
        foreach (drv[i]) n += drv[i].size();
        foreach (exp_q[i]) n += exp_q[i].size();
        return n != 0;
    endfunction

    task automatic drain(input string tag);
        int n = 0;
        while (busy() && n < 3000) begin
            cycle();
            n++;
        end
        chk({tag, "_drain"}, 32'(busy()), 32'd0);
        repeat (4) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ring_in_valid  = '0;
        local_in_valid = 1'b0;
        foreach (drv[i]) drv[i].delete();
        foreach (exp_q[i]) exp_q[i].delete();
        cur_q = '{-1, -1, -1};
        ord_ej.delete();
        ord_o0.delete();
        o0_valid_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int exp_o[5] = '{3, 4, 3, 4, 3};
        int n_ej, n_o0, src, len;
        logic [9:0] d;
        rst = 1'b1;
        gaps = 0; rand_rdy = 0; ro_rdy = 2'b11; lo_rdy = 1'b1;
        seq = '{default: 4'd0};
        ring_in_data = '0; ring_in_last = '0; ring_in_valid = '0;
        local_in_data = '0; local_in_last = 1'b0; local_in_valid = 1'b0;
        ring_out_ready = 2'b11; local_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ring_ready", ring_in_ready, 0);
        chk("rst_local_ready", local_in_ready, 0);
        chk("rst_valids", {ring_out_valid, local_out_valid}, 0);
        do_reset();
        #1;
        chk("post_rst_ring_ready", ring_in_ready, 2'b11);
        chk("post_rst_local_ready", local_in_ready, 1);

        make_pkt(0, MY_ID, 2);
        drain("t1");
        chk("t1_ej_pkts", ord_ej.size(), 1);
        chk("t1_ring0_quiet", o0_valid_cnt, 0);

        make_pkt(1, 10'd5, 3);
        cycle();
        chk("t2_accept", drv[1].size(), 2);
        chk("t2_not_yet", ring_out_valid[1], 0);
        cycle();
        chk("t2_latency", ring_out_valid[1], 1);
        drain("t2");

        do_reset();
        make_pkt(0, MY_ID, 2);
        make_pkt(1, MY_ID, 2);
        drain("t3");
        chk("t3_count", ord_ej.size(), 2);
        if (ord_ej.size() == 2) begin
            chk("t3_first", ord_ej[0], 1);
            chk("t3_second", ord_ej[1], 0);
        end

        do_reset();
        make_pkt(2, rand_dest(), 2);
        make_pkt(0, 10'd7, 2);
        drain("t4a");
        make_pkt(0, 10'd9, 2);
        drain("t4b");
        make_pkt(2, MY_ID, 2);
        make_pkt(0, 10'd11, 2);
        drain("t4c");
        chk("t4_count", ord_o0.size(), 5);
        if (ord_o0.size() == 5)
            for (int i = 0; i < 5; i++) chk($sformatf("t4_order%0d", i), ord_o0[i], exp_o[i]);

        do_reset();
        lo_rdy = 1'b0;
        make_pkt(0, MY_ID, 5);
        repeat (8) cycle();
        chk("t5_accepted", 5 - drv[0].size(), 4);
        chk("t5_ready_low", ring_in_ready[0], 0);
        chk("t5_local_valid", local_out_valid, 1);
        lo_rdy = 1'b1;
        drain("t5");
        chk("t5_pkts", ord_ej.size(), 1);

        do_reset();
        ro_rdy = 2'b01; lo_rdy = 1'b0;
        make_pkt(1, 10'd20, 3);
        make_pkt(0, MY_ID, 2);
        repeat (5) cycle();
        chk("t6_pre_fwd", ring_out_valid[1], 1);
        chk("t6_pre_ej", local_out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valids", {ring_out_valid, local_out_valid}, 0);
        chk("t6_rst_readies", {ring_in_ready, local_in_ready}, 0);
        do_reset();
        ro_rdy = 2'b11; lo_rdy = 1'b1;
        make_pkt(1, 10'd21, 2);
        make_pkt(0, MY_ID, 1);
        drain("t6");
        chk("t6_ej_pkts", ord_ej.size(), 1);

        do_reset();
        gaps = 1; rand_rdy = 1;
        n_ej = 0; n_o0 = 0;
        for (int k = 0; k < 45; k++) begin
            src = $urandom_range(0, 2);
            len = $urandom_range(1, 4);
            d = $urandom_range(0, 1) ? MY_ID : rand_dest();
            if (src != 2 && d == MY_ID) n_ej++;
            if (src == 2 || (src == 0 && d != MY_ID)) n_o0++;
            make_pkt(src, d, len);
        end
        drain("rand");
        chk("rand_ej_pkts", ord_ej.size(), n_ej);
        chk("rand_o0_pkts", ord_o0.size(), n_o0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
